fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined ARM core. It holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register consumed by the decode stage. It also supports pipeline stalls, flushes and taken branches from the execute stage, and keeps a fetch counter for debug. The instruction memory is combinational and word-indexed: address N returns instruction word N.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- BUBBLE_INSTR, 32'd0, instruction word placed in IF/ID on reset or flush.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- stall  input  1  hazard unit freeze request; holds PC and IF/ID.
- flush  input  1  squash request; bubble into IF/ID.
- branch_taken  input  1  execute-stage taken branch.
- branch_target  input  32  word index to fetch next when branch_taken.
- imem_address  output  32  word address to instruction memory; equals pc.
- imem_instruction  input  32  combinational instruction-memory data for imem_address.
- if_id_pc  output  32  registered pc+1 (word index of the next sequential instruction).
- if_id_instruction  output  32  registered instruction word.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_count  output  32  number of instructions latched with valid=1 since reset.

## Operation
- pc is a 32-bit register; imem_address = pc combinationally, with no extra register.
- PC next-state priority per edge: branch_taken -> pc = branch_target; else stall -> pc holds; else pc = pc + 1.
- IF/ID next-state priority per edge: flush or branch_taken -> instruction = BUBBLE_INSTR, if_id_pc = 0, valid = 0; else stall -> all IF/ID fields hold; else instruction = imem_instruction, if_id_pc = pc + 1, valid = 1.
- branch_taken implies squash of the wrong-path instruction currently fetched, even if flush is low.
- Simultaneous stall and branch_taken: the branch wins (PC redirects, IF/ID bubbles). Simultaneous stall and flush: flush wins for IF/ID, and PC holds.
- fetch_count increments by 1 on every edge where IF/ID loads with valid = 1. It holds otherwise and wraps at 2^32.
- Arithmetic: pc + 1 is modulo 2^32, so 32'hFFFF_FFFF wraps to 0. branch_target is used verbatim; the branch-offset computation (pc+1+signed imm24) belongs to execute.
- Two-state view: RESET (rst high, all outputs at reset values) and RUN. Each RUN edge performs one of REDIRECT, HOLD, BUBBLE or ADVANCE per the priorities above.

## Timing
- Reset values, applied asynchronously while rst is high: pc = RESET_PC, so imem_address = RESET_PC; if_id_pc = 0; if_id_instruction = BUBBLE_INSTR; if_id_valid = 0; fetch_count = 0.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. Any in-flight branch or stall request is discarded.
- Fetch latency is one cycle. The instruction at address N appears on if_id_instruction one edge after pc = N, provided there is no stall, flush or branch.
- First edge after rst deasserts (RESET_PC = 0): if_id_instruction = imem[0], if_id_pc = 1, if_id_valid = 1, pc = 1.
- Taken-branch penalty: branch_taken sampled at edge k gives pc = target after edge k and a bubble in IF/ID after edge k. The target instruction is in IF/ID after edge k+1.
- Stall of n cycles freezes pc, all IF/ID fields and fetch_count for exactly n edges.
- stall, flush, branch_taken and branch_target are sampled only at the rising edge. No combinational path runs from these inputs to the outputs.

## Test plan
- Reset and sequential fetch: release rst, run 4 edges -> if_id_pc goes 1,2,3,4; instructions are words 0..3; fetch_count = 4; pc = 4.
- Taken branch: with pc = 36, assert branch_taken with branch_target = 28 for one edge -> IF/ID valid = 0 and pc = 28. Next edge -> if_id_instruction = word 28, if_id_pc = 29.
- Stall: at pc = 10, hold stall for 3 edges -> pc stays 10, IF/ID unchanged, fetch_count unchanged. Deassert stall -> word 10 is latched.
- Stall+branch collision: assert stall and branch_taken (target 5) together -> pc = 5, if_id_valid = 0. Then stall+flush without branch -> pc holds and if_id_valid = 0.
- Wrap-around: branch to 32'hFFFF_FFFF, then advance 2 edges -> pc goes 0 then 1, and if_id_pc = 0 after the first of those edges.
- Asynchronous reset mid-run: assert rst between edges while pc = 17 -> outputs immediately take reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID signal bundle
interface fetch_stage_if;
  // pipeline control from hazard unit / execute
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  // instruction memory (combinational, word-indexed)
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  // IF/ID pipeline register and debug counter
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  // fetch stage side
  modport master (
    input  stall, flush, branch_taken, branch_target, imem_instruction,
    output imem_address, if_id_pc, if_id_instruction, if_id_valid, fetch_count
  );

  // surrounding pipeline / memory side
  modport slave (
    output stall, flush, branch_taken, branch_target, imem_instruction,
    input  imem_address, if_id_pc, if_id_instruction, if_id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem address, IF/ID register, fetch counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter logic [31:0] BUBBLE_INSTR = 32'd0
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  // What the IF/ID register does on a given edge
  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_ADVANCE = 2'd2
  } ifid_action_e;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  pc_plus1;
  ifid_action_e ifid_action;

  // Sequential successor wraps naturally at 2^32
  assign pc_plus1 = pc_q + 32'd1;

  // Next-state decode: a taken branch redirects the PC and squashes the
  // wrong-path fetch; flush only squashes, so the PC still follows stall
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    ifid_action   = IFID_HOLD;

    if (bus.branch_taken) begin
      pc_d = bus.branch_target;
    end else if (!bus.stall) begin
      pc_d = pc_plus1;
    end

    if (bus.flush || bus.branch_taken) begin
      ifid_action = IFID_BUBBLE;
    end else if (!bus.stall) begin
      ifid_action = IFID_ADVANCE;
    end

    case (ifid_action)
      IFID_BUBBLE: begin
        if_id_instr_d = BUBBLE_INSTR;
        if_id_pc_d    = 32'd0;
        if_id_valid_d = 1'b0;
      end
      IFID_ADVANCE: begin
        if_id_instr_d = bus.imem_instruction;
        if_id_pc_d    = pc_plus1;
        if_id_valid_d = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset clears everything immediately, dropping any pending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= BUBBLE_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_address      = pc_q;
  assign bus.if_id_pc          = if_id_pc_q;
  assign bus.if_id_instruction = if_id_instr_q;
  assign bus.if_id_valid       = if_id_valid_q;
  assign bus.fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC     (32'd0),
    .BUBBLE_INSTR (32'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word N holds {8'hE3, N[23:0]}
  assign bus.imem_instruction = {8'hE3, bus.imem_address[23:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] instr, input logic valid, input logic [31:0] cnt);
    check({tag, ".pc"},    bus.imem_address,              pc);
    check({tag, ".ifpc"},  bus.if_id_pc,                  ipc);
    check({tag, ".instr"}, bus.if_id_instruction,         instr);
    check({tag, ".valid"}, {31'd0, bus.if_id_valid},      {31'd0, valid});
    check({tag, ".count"}, bus.fetch_count,               cnt);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;

    #3;
    check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    #1 rst = 1'b0;

    // Sequential fetch, words 0..3
    step(); check_state("seq1", 32'd1, 32'd1, 32'hE300_0000, 1'b1, 32'd1);
    step(); check_state("seq2", 32'd2, 32'd2, 32'hE300_0001, 1'b1, 32'd2);
    step(); check_state("seq3", 32'd3, 32'd3, 32'hE300_0002, 1'b1, 32'd3);
    step(); check_state("seq4", 32'd4, 32'd4, 32'hE300_0003, 1'b1, 32'd4);

    // Run to pc = 10
    for (int i = 0; i < 6; i++) step();
    check_state("pre_stall", 32'd10, 32'd10, 32'hE300_0009, 1'b1, 32'd10);

    // Stall three edges
    bus.stall = 1'b1;
    step(); check_state("stall1", 32'd10, 32'd10, 32'hE300_0009, 1'b1, 32'd10);
    step(); check_state("stall2", 32'd10, 32'd10, 32'hE300_0009, 1'b1, 32'd10);
    step(); check_state("stall3", 32'd10, 32'd10, 32'hE300_0009, 1'b1, 32'd10);
    bus.stall = 1'b0;
    step(); check_state("unstall", 32'd11, 32'd11, 32'hE300_000A, 1'b1, 32'd11);

    // Run to pc = 36, then branch to 28
    for (int i = 0; i < 25; i++) step();
    check("pre_br.pc", bus.imem_address, 32'd36);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd28;
    step(); check_state("branch", 32'd28, 32'd0, 32'd0, 1'b0, 32'd36);
    bus.branch_taken  = 1'b0;
    step(); check_state("br_tgt", 32'd29, 32'd29, 32'hE300_001C, 1'b1, 32'd37);

    // Stall + branch: branch wins
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd5;
    step(); check_state("stall_br", 32'd5, 32'd0, 32'd0, 1'b0, 32'd37);
    // Stall + flush: PC holds, IF/ID bubbles
    bus.branch_taken  = 1'b0;
    bus.flush         = 1'b1;
    step(); check_state("stall_fl", 32'd5, 32'd0, 32'd0, 1'b0, 32'd37);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    step(); check_state("resume", 32'd6, 32'd6, 32'hE300_0005, 1'b1, 32'd38);
    // Flush alone: PC advances, IF/ID bubbles
    bus.flush = 1'b1;
    step(); check_state("flush", 32'd7, 32'd0, 32'd0, 1'b0, 32'd38);
    bus.flush = 1'b0;

    // Wrap-around
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFF;
    step(); check_state("br_max", 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'd38);
    bus.branch_taken  = 1'b0;
    step(); check_state("wrap1", 32'd0, 32'd0, 32'hE3FF_FFFF, 1'b1, 32'd39);
    step(); check_state("wrap2", 32'd1, 32'd1, 32'hE300_0000, 1'b1, 32'd40);

    // Async reset between edges at pc = 17, with requests pending
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd17;
    step();
    check("pre_rst.pc", bus.imem_address, 32'd17);
    bus.branch_target = 32'd99;
    bus.stall         = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    #2;
    rst              = 1'b0;
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    step(); check_state("post_rst", 32'd1, 32'd1, 32'hE300_0000, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
